// File: rtl/softmax_exp_sched_pkg.sv
// Shared types, widths and number-format helpers for the softmax exp scheduler.
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        SUM   = 3'd4
    } state_t;

    // Score format: sign-magnitude, [16] sign, [15:12] integer, [11:0] fraction.
    localparam int X_W   = 17;
    // Exp word: {position[4:0], mantissa[15:0]}.
    localparam int EXP_W = 21;
    // Two's complement working width; holds differences down to -20.0.
    localparam int TC_W  = 18;
    // -10.0 in sign-magnitude: floor applied to max-subtracted scores.
    localparam logic [X_W-1:0] SAT_NEG = 17'h1A000;

    // Sign-magnitude to two's complement; -0 decodes to 0.
    function automatic logic signed [TC_W-1:0] sm_to_tc(input logic [X_W-1:0] x);
        logic signed [TC_W-1:0] mag;
        mag = $signed({2'b00, x[15:0]});
        return x[16] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude; magnitude clipped to 16 bits.
    function automatic logic [X_W-1:0] tc_to_sm(input logic signed [TC_W-1:0] v);
        logic signed [TC_W-1:0] mag;
        mag = v[TC_W-1] ? -v : v;
        if (mag[TC_W-1:16] != 2'b00) begin
            return {v[TC_W-1], 16'hFFFF};
        end
        return {v[TC_W-1], mag[15:0]};
    endfunction

    // Linearise an exp word: mantissa scaled by its position; tiny values vanish.
    function automatic logic [15:0] exp_lin(input logic [EXP_W-1:0] w);
        logic [4:0] pos;
        pos = w[20:16];
        if (pos <= 5'd16) begin
            return w[15:0] >> (5'd16 - pos);
        end
        return 16'd0;
    endfunction

endpackage

// File: rtl/softmax_exp_sched_exp.sv
// Approximate exp for non-positive arguments: exp(-m) = 2^-(n+f) ~ (1 - f/2) * 2^-n,
// where n+f = m*log2(e). Purely combinational.
module softmax_exp_sched_exp
    import softmax_pkg::*;
(
    input  logic [X_W-1:0]   i_x,
    output logic [EXP_W-1:0] o_word
);

    // log2(e) in Q1.15.
    localparam logic [15:0] LOG2E = 16'hB8AB;

    logic [31:0] w_prod;
    logic [15:0] w_t;
    logic [3:0]  w_n;
    logic [11:0] w_f;
    logic [15:0] w_mant;
    logic [4:0]  w_pos;
    logic        w_unused;

    // Magnitude (Q4.12) times log2(e) (Q1.15), truncated back to Q4.12.
    assign w_prod = 32'(i_x[15:0]) * 32'(LOG2E);
    assign w_t    = w_prod[30:15];
    assign w_n    = w_t[15:12];
    assign w_f    = w_t[11:0];

    // Mantissa is 1 - f/2 in Q1.15, always in (0.5, 1.0].
    assign w_mant = 16'h8000 - {2'b00, w_f, 2'b00};
    assign w_pos  = 5'd16 - {1'b0, w_n};
    assign o_word = {w_pos, w_mant};

    // Sign is known negative (or zero) and low product bits are truncated.
    assign w_unused = ^{i_x[16], w_prod[31], w_prod[14:0]};

endmodule

// File: rtl/softmax_exp_sched.sv
// Buffers one softmax vector, tracks its maximum, then streams max-subtracted
// scores through a shared exp unit and reports the linearised exp sum.
module softmax_exp_sched
    import softmax_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int SUM_W   = 17 + $clog2(MAX_LEN)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_data,
    output logic             out_last,
    output logic             sum_valid,
    output logic [SUM_W-1:0] sum_data,
    output logic             busy,
    output logic             err_len
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_LEN - 1);
    localparam logic signed [TC_W-1:0] SAT_TC = sm_to_tc(SAT_NEG);

    // Clip a max-subtracted score into [-10.0, 0] and re-encode it.
    function automatic logic [X_W-1:0] sat_diff(input logic signed [TC_W-1:0] d);
        if (d < SAT_TC) begin
            return SAT_NEG;
        end
        if (!d[TC_W-1]) begin
            return '0;
        end
        return tc_to_sm(d);
    endfunction

    // Saturating accumulate of one linearised exp word.
    function automatic logic [SUM_W-1:0] sat_acc(input logic [SUM_W-1:0] a,
                                                 input logic [15:0]      b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W-15){1'b0}}, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    state_t                 r_state, w_next;
    logic [X_W-1:0]         r_buf [MAX_LEN];
    logic [CNT_W-1:0]       r_cnt, r_len, r_idx;
    logic signed [TC_W-1:0] r_max;
    logic [SUM_W-1:0]       r_acc, r_sum;
    logic                   r_err;

    logic [X_W-1:0]         r_d_p1;
    logic                   r_vld_p1, r_last_p1;
    logic [EXP_W-1:0]       r_word_p2;
    logic                   r_vld_p2, r_last_p2;

    logic signed [TC_W-1:0] w_score, w_diff;
    logic [EXP_W-1:0]       w_exp_word;
    logic [SUM_W-1:0]       w_acc_nxt;
    logic                   w_in_hs, w_adv, w_issue, w_issue_last, w_out_hs, w_ovf;

    assign w_score      = sm_to_tc(in_data);
    assign w_in_hs      = in_valid & in_ready;
    // A waiting output word freezes the whole issue pipe.
    assign w_adv        = ~(r_vld_p2 & ~out_ready);
    assign w_issue      = (r_state == ISSUE) & w_adv;
    assign w_issue_last = w_issue & (r_idx == r_len - ONE);
    assign w_out_hs     = r_vld_p2 & out_ready;
    assign w_ovf        = (r_state == LOAD) & w_in_hs & ~in_last & (r_cnt == LAST_SLOT);
    assign w_diff       = sm_to_tc(r_buf[r_idx[IDX_W-1:0]]) - r_max;
    assign w_acc_nxt    = sat_acc(r_acc, exp_lin(r_word_p2));

    assign in_ready  = (r_state == IDLE) | (r_state == LOAD);
    assign busy      = (r_state != IDLE);
    assign sum_valid = (r_state == SUM);
    assign out_valid = r_vld_p2;
    assign out_data  = r_word_p2;
    assign out_last  = r_last_p2;
    assign sum_data  = r_sum;
    assign err_len   = r_err;

    // Next-state decode for the vector sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = in_last ? ISSUE : LOAD;
            LOAD:    if (in_valid && (in_last || r_cnt == LAST_SLOT)) w_next = ISSUE;
            ISSUE:   if (w_issue_last) w_next = DRAIN;
            DRAIN:   if (w_out_hs && r_last_p2) w_next = SUM;
            SUM:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Load counter, running maximum, vector length, issue index and length error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_len <= '0;
            r_idx <= '0;
            r_max <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (w_in_hs) begin
                        r_cnt <= ONE;
                        r_len <= ONE;
                        r_max <= w_score;
                    end
                end
                LOAD: begin
                    if (w_in_hs) begin
                        r_cnt <= r_cnt + ONE;
                        if (w_score > r_max) r_max <= w_score;
                        if (in_last || r_cnt == LAST_SLOT) r_len <= r_cnt + ONE;
                        if (w_ovf) r_err <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_issue) r_idx <= r_idx + ONE;
                end
                SUM: begin
                    r_cnt <= '0;
                    r_max <= '0;
                    r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Valid and last flags travelling with the S1/S2 data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else if (w_adv) begin
            // S1: issued element enters
            r_vld_p1  <= w_issue;
            r_last_p1 <= w_issue_last;
            // S2: exp word presented downstream
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
        end
    end

    // Score buffer and pipeline data registers; contents qualified by the flags above.
    always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[r_cnt[IDX_W-1:0]] <= in_data;
        // S1: max-subtracted, clipped, sign-magnitude
        if (w_issue) r_d_p1 <= sat_diff(w_diff);
        // S2: exp unit result
        if (w_adv) r_word_p2 <= w_exp_word;
    end

    // Exp sum accumulator and the per-vector sum presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sum <= '0;
        end else if (w_out_hs) begin
            r_acc <= w_acc_nxt;
            if (r_last_p2) r_sum <= w_acc_nxt;
        end else if (r_state == SUM) begin
            r_acc <= '0;
        end
    end

    softmax_exp_sched_exp u_exp (
        .i_x    (r_d_p1),
        .o_word (w_exp_word)
    );

endmodule

// File: tb/tb_softmax_exp_sched.sv
// Scoreboard bench for softmax_exp_sched: stimulus pushes hand-computed exp words
// and sums; a negedge monitor pops and compares on every output handshake.
module tb_softmax_exp_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [16:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [20:0] out_data;
    logic        sum_valid, busy, err_len;
    logic [20:0] sum_data;

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    logic [21:0] exp_q[$];
    logic [20:0] sum_q[$];

    logic        stall_prev = 1'b0;
    logic        sum_due    = 1'b0;
    logic [20:0] prev_data, sum_exp;
    logic        prev_last;
    logic [21:0] e_word;

    // Hand-computed exp words for max-subtracted differences.
    localparam logic [20:0] W_0    = 21'h108000;  // d =  0.0
    localparam logic [20:0] W_M05  = 21'h1051D8;  // d = -0.5
    localparam logic [20:0] W_M1   = 21'h0F63AC;  // d = -1.0
    localparam logic [20:0] W_M2   = 21'h0E4758;  // d = -2.0
    localparam logic [20:0] W_M5   = 21'h097258;  // d = -5.0
    localparam logic [20:0] W_M10  = 21'h0264AC;  // d = -10.0 (and anything clipped there)

    // Mixed vector: max is +3.0, two entries clip to -10.
    logic [16:0] d_sc [16] = '{17'h02000, 17'h01000, 17'h02800, 17'h17000,
                               17'h19000, 17'h03000, 17'h02800, 17'h02000,
                               17'h01000, 17'h03000, 17'h17000, 17'h02000,
                               17'h02800, 17'h01000, 17'h19000, 17'h03000};
    logic [20:0] d_w  [16] = '{W_M1,  W_M2,  W_M05, W_M10,
                               W_M10, W_0,   W_M05, W_M1,
                               W_M2,  W_0,   W_M10, W_M1,
                               W_M05, W_M2,  W_M10, W_0};

    softmax_exp_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sum_valid (sum_valid),
        .sum_data  (sum_data),
        .busy      (busy),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic expect_word(input logic [20:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    // Offer one score and hold it until accepted (bounded).
    task automatic send(input logic [16:0] d, input logic last);
        logic ok;
        int   t;
        ok = 1'b0;
        t  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check("in_accept_timeout", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for the sequencer to return to IDLE, then confirm all words came out.
    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 400);
        check({name, "_done"}, {31'd0, busy}, 32'd0);
        check({name, "_words_left"}, exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_out_last"},  {31'd0, out_last},  32'd0);
        check({name, "_sum_valid"}, {31'd0, sum_valid}, 32'd0);
        check({name, "_sum_data"},  {11'd0, sum_data},  32'd0);
        check({name, "_busy"},      {31'd0, busy},      32'd0);
        check({name, "_err_len"},   {31'd0, err_len},   32'd0);
    endtask

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: stall stability, word scoreboard, sum timing and value.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            sum_due    = 1'b0;
        end else begin
            if (sum_due) begin
                check("sum_valid_after_last", {31'd0, sum_valid}, 32'd1);
                if (sum_valid) check("sum_data", {11'd0, sum_data}, {11'd0, sum_exp});
                sum_due = 1'b0;
            end else if (sum_valid) begin
                check("sum_valid_unexpected", {31'd0, sum_valid}, 32'd0);
            end
            if (stall_prev) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data",  {11'd0, out_data},  {11'd0, prev_data});
                check("stall_last",  {31'd0, out_last},  {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {11'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e_word = exp_q.pop_front();
                    check("out_data", {11'd0, out_data}, {11'd0, e_word[20:0]});
                    check("out_last", {31'd0, out_last}, {31'd0, e_word[21]});
                end
                if (out_last) begin
                    sum_due = 1'b1;
                    sum_exp = (sum_q.size() != 0) ? sum_q.pop_front() : 21'h1FFFFF;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four equal scores: every difference is zero.
        for (int i = 0; i < 4; i++) expect_word(W_0, i == 3);
        sum_q.push_back(21'h020000);
        for (int i = 0; i < 4; i++) send(17'h01000, i == 3);
        check("issue_in_ready", {31'd0, in_ready}, 32'd0);
        check("issue_busy",     {31'd0, busy},     32'd1);
        wait_idle("vec_equal");

        // +10 then -10: second difference is -20, clipped to -10.
        expect_word(W_0, 1'b0);
        expect_word(W_M10, 1'b1);
        sum_q.push_back(21'h008001);
        send(17'h0A000, 1'b0);
        send(17'h1A000, 1'b1);
        wait_idle("vec_sat");

        // Single -0 score.
        expect_word(W_0, 1'b1);
        sum_q.push_back(21'h008000);
        send(17'h10000, 1'b1);
        wait_idle("vec_negzero");

        // Full-length mixed vector under random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) expect_word(d_w[i], i == 15);
        sum_q.push_back(21'h034090);
        for (int i = 0; i < 16; i++) send(d_sc[i], i == 15);
        wait_idle("vec_stall");
        rdy_mode = 0;

        // Seventeen scores with no last: overflow forces issue after sixteen.
        for (int i = 0; i < 16; i++) expect_word(W_0, i == 15);
        sum_q.push_back(21'h080000);
        for (int i = 0; i < 16; i++) send(17'h00000, 1'b0);
        check("ovf_err_len",  {31'd0, err_len},  32'd1);
        check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 17'h05000;
        repeat (5) begin
            @(negedge clk);
            check("ovf_17th_blocked", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle("vec_ovf");
        check("ovf_err_sticky", {31'd0, err_len},  32'd1);
        check("ovf_idle_ready", {31'd0, in_ready}, 32'd1);

        // Reset while the only word waits in DRAIN.
        rdy_mode = 2;
        send(17'h01000, 1'b1);
        repeat (4) @(negedge clk);
        check("drain_busy",      {31'd0, busy},      32'd1);
        check("drain_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        sum_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All-negative vector after reset: max is -5.
        expect_word(W_M5, 1'b0);
        expect_word(W_0, 1'b1);
        sum_q.push_back(21'h0080E4);
        send(17'h1A000, 1'b0);
        send(17'h15000, 1'b1);
        wait_idle("vec_after_reset");
        check("after_reset_err_len", {31'd0, err_len}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
